// File: rtl/smux_pkg.sv
// Shared definitions for the smux sequencer: datapath widths, default round limits, FSM states.
package smux_pkg;

    localparam int DATA_W       = 136;
    localparam int CNT_W        = 4;
    localparam int LAST_CNT_DEF = 14;
    localparam int FLAG_CNT_DEF = 14;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        LOAD   = 2'd1,
        RUN    = 2'd2,
        FINISH = 2'd3
    } seq_state_t;

endpackage

// File: rtl/smux_seq_if.sv
// Bus between smux_seq and its neighbours: start/load request, smux control/return path, result.
// Optional abort input appears when SMUX_SEQ_ABORT_EN is defined.
interface smux_seq_if;
    import smux_pkg::*;

    logic              start;
    logic [DATA_W-1:0] load_data;
    logic [DATA_W-1:0] mux_data;
    logic              mux_flag;
    logic [CNT_W-1:0]  scounter;
    logic [DATA_W-1:0] state_q;
    logic              busy;
    logic              done;
    logic [DATA_W-1:0] result;
`ifdef SMUX_SEQ_ABORT_EN
    logic              abort;

    modport slave (
        input  start, load_data, mux_data, abort,
        output mux_flag, scounter, state_q, busy, done, result
    );
    modport master (
        output start, load_data, mux_data, abort,
        input  mux_flag, scounter, state_q, busy, done, result
    );
`else
    modport slave (
        input  start, load_data, mux_data,
        output mux_flag, scounter, state_q, busy, done, result
    );
    modport master (
        output start, load_data, mux_data,
        input  mux_flag, scounter, state_q, busy, done, result
    );
`endif

endinterface

// File: rtl/smux_round_cnt.sv
// Saturating round counter with clear/enable and a registered ">= FLAG_CNT" flag.
module smux_round_cnt #(
    parameter int CNT_W    = 4,
    parameter int LAST_CNT = 14,
    parameter int FLAG_CNT = 14
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr,
    input  logic             en,
    input  logic             flag_en,
    output logic [CNT_W-1:0] count,
    output logic             flag
);

    logic [CNT_W-1:0] count_next;

    always_comb begin
        count_next = count;
        if (clr) begin
            count_next = '0;
        end else if (en && (count != CNT_W'(LAST_CNT))) begin
            count_next = count + CNT_W'(1);
        end
    end

    // The flag is computed from the next count so it changes on the same edge as the counter.
    always_ff @(posedge clk) begin
        if (rst) begin
            count <= '0;
            flag  <= 1'b0;
        end else begin
            count <= count_next;
            flag  <= flag_en && (count_next >= CNT_W'(FLAG_CNT));
        end
    end

endmodule

// File: rtl/smux_seq.sv
// Sequencer driving smux rounds: loads a word, captures LAST_CNT+1 smux outputs, pulses done.
// Define SMUX_SEQ_ABORT_EN to add the abort input that cancels a sequence in LOAD/RUN.
module smux_seq
    import smux_pkg::*;
#(
    parameter int LAST_CNT = LAST_CNT_DEF,
    parameter int FLAG_CNT = FLAG_CNT_DEF
) (
    input logic       clk,
    input logic       rst,
    smux_seq_if.slave bus
);

    seq_state_t        fsm_state;
    logic [DATA_W-1:0] state_q_r;
    logic [DATA_W-1:0] result_r;
    logic              busy_r;
    logic              done_r;
    logic [CNT_W-1:0]  count;
    logic              flag;

    logic abort_req;
    logic abort_hit;
    logic start_ok;
    logic last_round;
    logic cnt_clr;
    logic cnt_en;
    logic busy_next;

`ifdef SMUX_SEQ_ABORT_EN
    assign abort_req = bus.abort;
`else
    assign abort_req = 1'b0;
`endif

    // Abort only acts mid-sequence, but in IDLE it still suppresses a simultaneous start.
    always_comb begin
        abort_hit  = abort_req && ((fsm_state == LOAD) || (fsm_state == RUN));
        start_ok   = (fsm_state == IDLE) && bus.start && !abort_req;
        last_round = (fsm_state == RUN) && (count == CNT_W'(LAST_CNT));
        cnt_clr    = start_ok || abort_hit;
        cnt_en     = (fsm_state == RUN) && !abort_hit;
        busy_next  = start_ok ||
                     (((fsm_state == LOAD) || (fsm_state == RUN)) && !abort_hit && !last_round);
    end

    smux_round_cnt #(
        .CNT_W    (CNT_W),
        .LAST_CNT (LAST_CNT),
        .FLAG_CNT (FLAG_CNT)
    ) u_round_cnt (
        .clk     (clk),
        .rst     (rst),
        .clr     (cnt_clr),
        .en      (cnt_en),
        .flag_en (busy_next),
        .count   (count),
        .flag    (flag)
    );

    // result is loaded on the edge entering FINISH so it is already valid while done is high.
    always_ff @(posedge clk) begin
        if (rst) begin
            fsm_state <= IDLE;
            state_q_r <= '0;
            result_r  <= '0;
            busy_r    <= 1'b0;
            done_r    <= 1'b0;
        end else begin
            done_r <= 1'b0;
            busy_r <= busy_next;
            case (fsm_state)
                IDLE: begin
                    if (start_ok) begin
                        state_q_r <= bus.load_data;
                        fsm_state <= LOAD;
                    end
                end
                LOAD: begin
                    fsm_state <= abort_hit ? IDLE : RUN;
                end
                RUN: begin
                    if (abort_hit) begin
                        fsm_state <= IDLE;
                    end else begin
                        state_q_r <= bus.mux_data;
                        if (last_round) begin
                            result_r  <= bus.mux_data;
                            done_r    <= 1'b1;
                            fsm_state <= FINISH;
                        end
                    end
                end
                FINISH: begin
                    fsm_state <= IDLE;
                end
                default: begin
                    fsm_state <= IDLE;
                end
            endcase
        end
    end

    assign bus.mux_flag = flag;
    assign bus.scounter = count;
    assign bus.state_q  = state_q_r;
    assign bus.busy     = busy_r;
    assign bus.done     = done_r;
    assign bus.result   = result_r;

endmodule
